// File: rtl/board_reader_pkg.sv
// ---------------------------------------------------------------------------
// board_reader_pkg
// Shared constants and types for the board readout block:
//   - board geometry (11x11 board, 121 cells, 242 plane bits)
//   - cell codes reported on out_cell
//   - game status codes captured into snap_status
//   - FSM state type used by board_reader
//   - cell_code(): packs the two plane bits of one cell into a cell code
// ---------------------------------------------------------------------------
package board_reader_pkg;

  localparam int BOARD_DIM   = 11;
  localparam int BOARD_CELLS = 121;
  localparam int BOARD_BITS  = 242;

  // Address of the final cell of a readout.
  localparam logic [7:0] LAST_ADDR = 8'd120;
  // Offset of the player1 plane inside the chessboard vector.
  localparam logic [7:0] P1_OFFSET = 8'd121;

  // Cell codes: bit0 = player0 plane, bit1 = player1 plane.
  localparam logic [1:0] CELL_EMPTY   = 2'd0;
  localparam logic [1:0] CELL_P0      = 2'd1;
  localparam logic [1:0] CELL_P1      = 2'd2;
  localparam logic [1:0] CELL_ILLEGAL = 2'd3;

  // Game status codes.
  localparam logic [1:0] GS_PROCESSING = 2'd0;
  localparam logic [1:0] GS_P0_WIN     = 2'd1;
  localparam logic [1:0] GS_P1_WIN     = 2'd2;
  localparam logic [1:0] GS_TIE        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Both plane bits set yields CELL_ILLEGAL naturally.
  function automatic logic [1:0] cell_code(input logic p0_bit, input logic p1_bit);
    return {p1_bit, p0_bit};
  endfunction

endpackage

// File: rtl/board_cell_mux.sv
// ---------------------------------------------------------------------------
// board_cell_mux
// Combinational selection of one cell from the board snapshot.
// Ports:
//   board_i [241:0] : snapshot planes, player0 bits 0..120, player1 bits 121..241
//   win_i   [120:0] : snapshot winning-line mask (all zero when not built)
//   addr_i  [7:0]   : cell index 0..120
//   cell_o  [1:0]   : {player1 bit, player0 bit} of the addressed cell
//   win_o           : win mask bit of the addressed cell
// Addresses beyond the board return an empty, non-winning cell.
// ---------------------------------------------------------------------------
module board_cell_mux
  import board_reader_pkg::*;
(
  input  logic [241:0] board_i,
  input  logic [120:0] win_i,
  input  logic [7:0]   addr_i,
  output logic [1:0]   cell_o,
  output logic         win_o
);

  // Select the two plane bits and the win bit at addr_i.
  always_comb begin
    cell_o = CELL_EMPTY;
    win_o  = 1'b0;
    if (addr_i <= LAST_ADDR) begin
      // addr_i <= 120, so addr_i + 121 <= 241 fits in 8 bits and addr_i fits in 7.
      cell_o = cell_code(board_i[addr_i], board_i[addr_i + P1_OFFSET]);
      win_o  = win_i[addr_i[6:0]];
    end else begin
      cell_o = CELL_EMPTY;
      win_o  = 1'b0;
    end
  end

endmodule

// File: rtl/board_reader.sv
// ---------------------------------------------------------------------------
// board_reader
// Snapshots an 11x11 two-player board on start and streams it out one cell
// per accepted beat (valid/ready), addresses 0..120, followed by a one-cycle
// done pulse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : readout request, honoured only in IDLE
//   chessboard [241:0]: player0 plane (0..120) then player1 plane (121..241)
//   win_board  [120:0]: winning-line mask
//   game_status [1:0] : game status, captured at snapshot into snap_status
//   busy              : readout in progress
//   out_valid/out_ready: beat handshake
//   out_addr [7:0]    : cell index of the current beat
//   out_cell [1:0]    : cell code of the current beat
//   out_win           : win mask bit of the current beat
//   out_last          : current beat is cell 120
//   snap_status [1:0] : game_status captured at the last snapshot
//   done              : one-cycle pulse after the final beat
// Configuration:
//   BOARD_READER_WIN_EN : when defined, win_board is snapshotted and driven on
//   out_win; otherwise no win register exists and out_win is constant 0.
// ---------------------------------------------------------------------------
module board_reader
  import board_reader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [241:0] chessboard,
  input  logic [120:0] win_board,
  input  logic [1:0]   game_status,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_addr,
  output logic [1:0]   out_cell,
  output logic         out_win,
  output logic         out_last,
  output logic [1:0]   snap_status,
  output logic         done
);

  state_e       state_q,       state_d;
  logic [7:0]   addr_q,        addr_d;
  logic [241:0] snap_board_q,  snap_board_d;
  logic [1:0]   snap_status_q, snap_status_d;
  logic [120:0] win_sel_s;
  logic [1:0]   mux_cell_s;
  logic         mux_win_s;
  logic         streaming_s;
  logic         xfer_s;

`ifdef BOARD_READER_WIN_EN
  logic [120:0] snap_win_q, snap_win_d;

  // Win mask snapshot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_win_q <= 121'd0;
    end else begin
      snap_win_q <= snap_win_d;
    end
  end

  // Capture win_board only on an accepted start.
  always_comb begin
    snap_win_d = snap_win_q;
    if ((state_q == ST_IDLE) && start) begin
      snap_win_d = win_board;
    end else begin
      snap_win_d = snap_win_q;
    end
  end

  assign win_sel_s = snap_win_q;
`else
  // win_board is intentionally left unconnected in this build.
  logic unused_win_board_s;
  assign unused_win_board_s = ^win_board;
  assign win_sel_s          = 121'd0;
`endif

  assign streaming_s = (state_q == ST_STREAM);
  assign xfer_s      = streaming_s && out_ready;

  // State, address and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= 8'd0;
      snap_board_q  <= 242'd0;
      snap_status_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      snap_board_q  <= snap_board_d;
      snap_status_q <= snap_status_d;
    end
  end

  // Next-state, address counter and snapshot capture.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    snap_board_d  = snap_board_q;
    snap_status_d = snap_status_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_STREAM;
          addr_d        = 8'd0;
          snap_board_d  = chessboard;
          snap_status_d = game_status;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // start is not looked at here, so a start during the stream
        // (including on the final transfer) is dropped.
        if (xfer_s) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
            addr_d  = 8'd0;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = 8'd0;
      end
    endcase
  end

  board_cell_mux u_cell_mux (
    .board_i (snap_board_q),
    .win_i   (win_sel_s),
    .addr_i  (addr_q),
    .cell_o  (mux_cell_s),
    .win_o   (mux_win_s)
  );

  // Output decode; beat fields are forced to zero whenever no beat is offered.
  always_comb begin
    busy        = streaming_s;
    out_valid   = streaming_s;
    done        = (state_q == ST_DONE);
    snap_status = snap_status_q;
    if (streaming_s) begin
      out_addr = addr_q;
      out_cell = mux_cell_s;
      out_win  = mux_win_s;
      out_last = (addr_q == LAST_ADDR);
    end else begin
      out_addr = 8'd0;
      out_cell = CELL_EMPTY;
      out_win  = 1'b0;
      out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_board_reader.sv
// ---------------------------------------------------------------------------
// tb_board_reader
// Scoreboard bench for board_reader: each readout pushes its 121 expected
// beats into a queue; a negedge monitor pops and compares on every transfer,
// checks stall stability, zeroed idle outputs and done timing.
// Honours BOARD_READER_WIN_EN for the expected out_win values.
// ---------------------------------------------------------------------------
module tb_board_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [241:0] chessboard;
  logic [120:0] win_board;
  logic [1:0]   game_status;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_addr;
  logic [1:0]   out_cell;
  logic         out_win;
  logic         out_last;
  logic [1:0]   snap_status;
  logic         done;

  board_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .chessboard  (chessboard),
    .win_board   (win_board),
    .game_status (game_status),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_cell    (out_cell),
    .out_win     (out_win),
    .out_last    (out_last),
    .snap_status (snap_status),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  bit in_reset  = 1'b1;
  bit prev_stall = 1'b0;
  logic [11:0] stall_snap;
  logic [11:0] exp_e;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold", {20'd0, out_addr, out_cell, out_win, out_last}, {20'd0, stall_snap});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual_addr=%0d expected=none", out_addr);
        end else begin
          exp_e = exp_q.pop_front();
          check("beat", {20'd0, out_addr, out_cell, out_win, out_last}, {20'd0, exp_e});
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_cnt++;
      end
      if (!out_valid) begin
        check("idle_zero", {20'd0, out_addr, out_cell, out_win, out_last}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("done_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        check("done_after_last", cyc, last_cyc + 1);
      end
      prev_stall = out_valid && !out_ready;
      stall_snap = {out_addr, out_cell, out_win, out_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One readout. mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
  // abort_at >= 0 asserts rst when that many beats have transferred.
  // perturb changes all inputs and re-pulses start mid-stream.
  task automatic run_stream(input logic [241:0] b, input logic [120:0] w, input logic [1:0] gs,
                            input int mode, input int abort_at, input bit perturb);
    int  base_done;
    int  k;
    bit  aborted;
    for (int a = 0; a < 121; a++) begin
      logic [7:0] a8;
      logic       we;
      a8 = a[7:0];
`ifdef BOARD_READER_WIN_EN
      we = w[a];
`else
      we = 1'b0;
`endif
      exp_q.push_back({a8, b[121 + a], b[a], we, (a == 120)});
    end
    xfer_cnt  = 0;
    base_done = done_cnt;
    aborted   = 1'b0;
    @(posedge clk); #1;
    chessboard  = b;
    win_board   = w;
    game_status = gs;
    start       = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("first_beat", {22'd0, busy, out_valid, out_addr}, {22'd0, 1'b1, 1'b1, 8'd0});
    k = 1;
    while (k < 3000 && done_cnt == base_done && !aborted) begin
      @(posedge clk); #1;
      if (mode == 1) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      else           out_ready = 1'b1;
      if (perturb && k == 10) begin
        chessboard  = ~b;
        win_board   = ~w;
        game_status = ~gs;
        start       = 1'b1;
      end
      if (perturb && k == 11) start = 1'b0;
      if (abort_at >= 0 && xfer_cnt == abort_at) begin
        check("abort_addr", {24'd0, out_addr}, abort_at);
        in_reset = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {16'd0, busy, out_valid, out_last, done, out_addr, out_cell, out_win, snap_status},
              32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        in_reset = 1'b0;
        aborted  = 1'b1;
      end
      k++;
    end
    if (aborted) begin
      repeat (5) @(posedge clk);
      #1;
      check("rst_no_done", done_cnt, base_done);
    end else begin
      check("done_seen", done_cnt, base_done + 1);
      check("xfer_count", xfer_cnt, 121);
      check("queue_empty", exp_q.size(), 0);
      if (mode == 0) check("back_to_back", last_cyc - first_cyc, 120);
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("single_done", done_cnt, base_done + 1);
      check("idle_after", {30'd0, busy, out_valid}, 32'd0);
      check("snap_status", {30'd0, snap_status}, {30'd0, gs});
    end
  endtask

  logic [241:0] stones;
  logic [120:0] five;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    out_ready   = 1'b0;
    chessboard  = 242'd0;
    win_board   = 121'd0;
    game_status = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {16'd0, busy, out_valid, out_last, done, out_addr, out_cell, out_win, snap_status}, 32'd0);
    @(posedge clk); #1;
    in_reset = 1'b0;

    // Empty board, ready high.
    run_stream(242'd0, 121'd0, 2'd0, 0, -1, 1'b0);

    // Stones: p0 at 60, p1 at 61, both planes at 5.
    stones = 242'd0;
    stones[60]  = 1'b1;
    stones[182] = 1'b1;
    stones[5]   = 1'b1;
    stones[126] = 1'b1;
    run_stream(stones, 121'd0, 2'd0, 0, -1, 1'b0);

    // Ready toggled 1,0,0,1.
    run_stream(stones, 121'd0, 2'd3, 1, -1, 1'b0);

    // Inputs changed and start re-pulsed mid-stream.
    run_stream(stones, 121'd0, 2'd2, 0, -1, 1'b1);

    // Reset at beat 50, then a full readout.
    run_stream(stones, 121'd0, 2'd1, 1, 50, 1'b0);
    run_stream(stones, 121'd0, 2'd0, 0, -1, 1'b0);

    // Horizontal five on cells 0..4, player0 win.
    five = 121'd0;
    five[4:0] = 5'b11111;
    run_stream({121'd0, 116'd0, 5'b11111}, five, 2'd1, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_reader.md
BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  request one full board readout; sampled only in IDLE.
REQ-004 chessboard  input  242  player0 plane bits 0..120 followed by player1 plane bits 121..241; cell index = row*11+col.
REQ-005 win_board  input  121  winning-line cell mask, same indexing.
REQ-006 game_status  input  2  0 processing, 1 player0 win, 2 player1 win, 3 tie.
REQ-007 busy  output  1  high from the snapshot edge until the done edge.
REQ-008 out_valid  output  1  cell beat valid.
REQ-009 out_ready  input  1  consumer accepts beat.
REQ-010 out_addr  output  8  cell index 0..120.
REQ-011 out_cell  output  2  0 empty, 1 player0, 2 player1, 3 both bits set (illegal).
REQ-012 out_win  output  1  win_board bit of the cell (see Configuration).
REQ-013 out_last  output  1  high on the beat with out_addr==120.
REQ-014 snap_status  output  2  game_status captured at snapshot, held until next snapshot.
REQ-015 done  output  1  one-cycle pulse after the last beat transfers.

Function
REQ-016 FSM states IDLE, STREAM, DONE; IDLE->STREAM on start; STREAM->DONE on transfer with out_last; DONE->IDLE unconditionally after one cycle.
REQ-017 On the IDLE edge with start=1, all 242+121+2 input bits are registered into internal snapshot registers; later input changes do not affect the current readout.
REQ-018 out_valid rises in the cycle after start is sampled, with out_addr=0; latency start->first beat is 1 cycle.
REQ-019 Transfer = out_valid & out_ready on a rising edge; out_addr increments by 1 per transfer; no increment past 120.
REQ-020 While out_valid=1 and out_ready=0, out_addr, out_cell, out_win, out_last hold stable; out_valid does not drop.
REQ-021 out_cell = {snapshot player1 bit, snapshot player0 bit} at out_addr.
REQ-022 Back-to-back transfers with out_ready held high: 121 beats in 121 consecutive cycles.
REQ-023 done=1 exactly in the DONE cycle; out_valid=0 and busy=0 in that cycle.
REQ-024 start while busy or in DONE is ignored; not queued.
REQ-025 start and the final transfer in the same cycle: start is ignored.
REQ-026 When out_valid=0, out_addr, out_cell, out_win and out_last are 0.

Reset
REQ-027 rst=1 on any edge, including mid-stream: state IDLE; busy, out_valid, out_last, done, out_addr, out_cell, out_win, snap_status all 0; snapshot registers cleared; no done pulse is produced.
REQ-028 The first start after rst deasserts is accepted normally.

Configuration
REQ-029 Macro BOARD_READER_WIN_EN: when defined, win_board is snapshotted and out_win carries the snapshot bit; when undefined, the win snapshot register is not built, out_win is constant 0, and the win_board port remains present but unused.

Structure
REQ-030 Shared package holds BOARD_DIM=11, BOARD_CELLS=121, the cell-code constants (EMPTY, P0, P1, ILLEGAL), the game-status codes and the FSM state typedef.
REQ-031 One sub-module, board_cell_mux: combinational selection of the cell code and win bit from the snapshot at out_addr; all FSM and counter logic stays in board_reader.

Verification
REQ-032 Empty board, out_ready=1, start pulse -> beats 0..120 in consecutive cycles, all out_cell=0, out_last only at addr 120, done one cycle later.
REQ-033 Stone at cell 60 for player0, cell 61 for player1, cell 5 with both bits set -> out_cell 1 at addr 60, 2 at addr 61, 3 at addr 5, 0 elsewhere.
REQ-034 out_ready toggled 1,0,0,1 repeatedly -> no beat skipped or duplicated, outputs stable during stalls, exactly 121 transfers.
REQ-035 Chessboard changed and start re-pulsed during streaming -> stream reflects the original snapshot, second start ignored, one done only.
REQ-036 rst asserted at beat 50 -> next cycle all outputs 0, no done; a new start gives a full readout from addr 0.
REQ-037 With BOARD_READER_WIN_EN, horizontal five at cells 0..4 and game_status=1 -> out_win=1 only at addr 0..4, snap_status=1; without the macro, out_win=0 throughout.
